step_pulse_gen: RTL
===================

Name: step_pulse_gen

Overview:
Upstream stage of the processor core. Turns a raw, bouncing push-button into a clean, single-cycle step enable for the processor. Also offers a free-running auto-step mode selected by a slide switch. The processor advances exactly one FSM state per StepEn pulse, so single-stepping on the FPGA becomes deterministic instead of clocking the core directly from a key.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples needed to accept a press or release (10 ms at 50 MHz); minimum 2
RUN_DIV, 25000000, Clk cycles between StepEn pulses in run mode; minimum 2
HOLD_CYCLES, 25000000, key-held time before auto-repeat starts (used only with STEP_REPEAT_EN)
REPEAT_CYCLES, 5000000, auto-repeat period (used only with STEP_REPEAT_EN)

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-low reset
KeyN  input  1  raw push-button, active-low, asynchronous to Clk
RunMode  input  1  raw slide switch; 1 = auto-step, 0 = manual step; asynchronous to Clk
StepEn  output  1  one-Clk-wide step enable to the processor
KeyLevel  output  1  debounced key state, 1 = pressed
StepCount  output  16  number of StepEn pulses issued, wraps

Behaviour:
- Reset (Reset=0, asynchronous, any time): StepEn=0, KeyLevel=0, StepCount=16'h0000. FSM goes to UP. Debounce counter and prescaler go to 0. Synchronizer flops go to the released/inactive value (KeyN sync=1, RunMode sync=0).
- Synchronization: KeyN and RunMode each pass through a 2-flop synchronizer. All logic below uses only the synchronized values.
- Debounce FSM states: UP, WAIT_DN, DOWN, WAIT_UP.
  - UP: when sync key is pressed, go to WAIT_DN with counter=1.
  - WAIT_DN: while pressed, the counter increments. If the sample shows released, go to UP and clear the counter. When the counter reaches DEBOUNCE_CYCLES, go to DOWN, set KeyLevel=1 and clear the counter.
  - DOWN: when sync key is released, go to WAIT_UP with counter=1.
  - WAIT_UP: mirror of WAIT_DN. A pressed sample returns to DOWN. Reaching DEBOUNCE_CYCLES goes to UP and sets KeyLevel=0.
- Manual step: StepEn=1 for exactly the one cycle after the WAIT_DN->DOWN transition, and only if sync RunMode=0.
  - Latency: a clean press first sampled low at edge 0 gives StepEn high after edge DEBOUNCE_CYCLES+2, for one cycle.
  - Release never produces a pulse.
- Run mode (sync RunMode=1):
  - The prescaler counts 0..RUN_DIV-1. StepEn=1 in the cycle the prescaler equals RUN_DIV-1, then the prescaler wraps to 0. The first pulse comes RUN_DIV cycles after sync RunMode rises.
  - Key presses are still debounced and KeyLevel still tracks the key, but they never produce StepEn.
  - Any change of sync RunMode clears the prescaler.
  - When RunMode=0, the prescaler is held at 0.
- StepCount: increments by 1, mod 2^16, in the same cycle StepEn is high (registered, visible the next cycle). It wraps from 16'hFFFF to 16'h0000.
- Simultaneous events: a manual pulse and a run pulse cannot coincide, because the mode gates the source. At most one StepEn per cycle, never two consecutive cycles (RUN_DIV≥2).
- Reset mid-debounce: the pending press is discarded. After reset release, the key must again be stable for DEBOUNCE_CYCLES.

Optional Feature:
STEP_REPEAT_EN
- Defined: in manual mode, while in DOWN, a hold counter runs. After HOLD_CYCLES in DOWN, StepEn pulses once, then again every REPEAT_CYCLES until leaving DOWN. The hold counter clears on leaving DOWN.
- Undefined: no hold counter or repeat logic is generated. Exactly one pulse per debounced press; HOLD_CYCLES and REPEAT_CYCLES are ignored.

Decomposition:
- Package step_pkg holds:
  - typedef enum logic [1:0] deb_state_t {UP, WAIT_DN, DOWN, WAIT_UP};
  - a localparam width helper for the counters ($clog2 of the max of the parameters).
- One sub-module, sync_2ff: a 1-bit two-flop synchronizer with asynchronous active-low reset and a parameter for the reset value. It is instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=8, HOLD_CYCLES=16, REPEAT_CYCLES=4):
- Reset: assert Reset=0 mid-WAIT_DN, between edges -> StepEn=0, KeyLevel=0 and StepCount=0 immediately. No pulse after release unless the key is re-held for 4 samples.
- Clean press: KeyN low at edge 0, held 12 cycles, then high -> one StepEn at edge 6, StepCount=1. KeyLevel rises at edge 6 and falls 6 cycles after KeyN rises.
- Bounce: KeyN low 3 cycles, high 1, low 3, high -> no StepEn, KeyLevel stays 0, StepCount=0.
- Run mode: RunMode=1 for 42 cycles with key presses interleaved -> StepEn every 8 cycles, 5 pulses, first 10 cycles after RunMode rises. StepCount=5. Presses add nothing.
- Wrap: RUN_DIV=2, RunMode=1 for 131072+ cycles -> StepCount passes 16'hFFFF to 16'h0000.
- With STEP_REPEAT_EN: hold KeyN low 30 cycles -> pulses at edges 6, 22 and 26 (edge 30 also if still held). Without the macro -> single pulse at edge 6.

Source files
------------

// File: rtl/step_pkg.sv
// step_pkg: shared debounce state encoding and counter width helper.
package step_pkg;
  typedef enum logic [1:0] {UP, WAIT_DN, DOWN, WAIT_UP} deb_state_t;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: debounced key -> one-cycle StepEn, plus free-running run mode.
// Define STEP_REPEAT_EN to add hold-to-auto-repeat in manual mode.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        KeyN,
  input  logic        RunMode,
  output logic        StepEn,
  output logic        KeyLevel,
  output logic [15:0] StepCount
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES, RUN_DIV, HOLD_CYCLES + REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB      = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RUN_END  = CW'(RUN_DIV - 1);
  localparam logic [CW-1:0] RUN_PEN  = CW'(RUN_DIV - 2);
  logic key_s, run_s, run_q, pressed, deb_fire, run_fire, rep_fire, step_nxt;
  logic [CW-1:0] cnt, pre;
  deb_state_t state;
  sync_2ff #(.RST_VAL(1'b1)) u_key (.clk(Clk), .rst_n(Reset), .d(KeyN),    .q(key_s));
  sync_2ff #(.RST_VAL(1'b0)) u_run (.clk(Clk), .rst_n(Reset), .d(RunMode), .q(run_s));
  assign pressed  = ~key_s;
  assign deb_fire = (state == WAIT_DN) && pressed && (cnt == DEB);
  // run pulse is registered, so fire one count early to land while pre == RUN_DIV-1
  assign run_fire = run_s && run_q && (pre == RUN_PEN);
`ifdef STEP_REPEAT_EN
  localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] HREP = CW'(HOLD_CYCLES + REPEAT_CYCLES);
  logic [CW-1:0] hold, hold_nxt;
  assign hold_nxt = hold + 1'b1;
  assign rep_fire = (state == DOWN) && (hold_nxt == HOLD || hold_nxt == HREP);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) hold <= '0;
    else hold <= (state != DOWN) ? '0 : (hold_nxt == HREP) ? HOLD : hold_nxt;
`else
  assign rep_fire = 1'b0;
`endif
  always_comb step_nxt = run_s ? run_fire : (deb_fire | rep_fire);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state    <= UP;
      cnt      <= '0;
      KeyLevel <= 1'b0;
    end else begin
      case (state)
        UP:
          if (pressed) begin
            state <= WAIT_DN;
            cnt   <= CW'(1);
          end
        WAIT_DN:
          if (!pressed) begin
            state <= UP;
            cnt   <= '0;
          end else if (cnt == DEB) begin
            state    <= DOWN;
            cnt      <= '0;
            KeyLevel <= 1'b1;
          end else cnt <= cnt + 1'b1;
        DOWN:
          if (!pressed) begin
            state <= WAIT_UP;
            cnt   <= CW'(1);
          end
        WAIT_UP:
          if (pressed) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == DEB) begin
            state    <= UP;
            cnt      <= '0;
            KeyLevel <= 1'b0;
          end else cnt <= cnt + 1'b1;
      endcase
    end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      run_q     <= 1'b0;
      pre       <= '0;
      StepEn    <= 1'b0;
      StepCount <= '0;
    end else begin
      run_q     <= run_s;
      pre       <= (run_s != run_q || !run_s || pre == RUN_END) ? '0 : pre + 1'b1;
      StepEn    <= step_nxt;
      StepCount <= StepCount + {15'b0, StepEn};
    end
endmodule
